// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: FSM states,
// next-PC mode encodings, the reset PC default and the F/D entry layout.
package fetch_ctrl_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam logic [2:0] NPC_ADD4 = 3'd0;
  localparam logic [2:0] NPC_BRCH = 3'd1;
  localparam logic [2:0] NPC_J    = 3'd2;
  localparam logic [2:0] NPC_JR   = 3'd3;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fd_entry_t;

  // Branch displacement: sign-extended word offset.
  function automatic logic [31:0] br_offset(input logic [15:0] imm16);
    return {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_ctrl_npc.sv
// Next-PC target computation for the instruction held in F/D.
// Branch and jump targets are relative to the delay-slot address.
module fetch_ctrl_npc
  import fetch_ctrl_pkg::*;
(
  input  logic [2:0]  npc_mod,
  input  logic [31:0] i_pc,
  input  logic [31:0] d_pc,
  input  logic [25:0] imm26,
  input  logic [31:0] reg32,
  output logic [31:0] target
);

  logic [31:0] slot_pc;

  assign slot_pc = d_pc + 32'd4;

  always_comb begin
    target = i_pc + 32'd4;
    case (npc_mod)
      NPC_BRCH: target = slot_pc + br_offset(imm26[15:0]);
      NPC_J:    target = {slot_pc[31:28], imm26, 2'b00};
      NPC_JR:   target = reg32;
      default:  target = i_pc + 32'd4;
    endcase
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding fetch, an F/D register with a
// one-entry skid buffer, and delayed-branch redirect handling.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        fd_valid,
  output logic [31:0] fd_pc,
  output logic [31:0] fd_instr,
  input  logic        d_accept,
  input  logic [2:0]  d_npc_mod,
  input  logic [31:0] d_reg32,
  output state_t      state
);

  // Handshakes: a fetch completes on any cycle where imem_req && imem_ready;
  // imem_addr is held until then. F/D is consumed when fd_valid && d_accept.

  state_t      state_q;
  logic [31:0] pc_q;
  logic        fd_valid_q;
  fd_entry_t   fd_q;
  fd_entry_t   skid_q;
  logic        redir_v_q;
  logic [31:0] redir_tgt_q;
  logic [31:0] redir_after_q;

  logic        accept;
  logic        cap;
  logic        done;
  logic        drop;
  logic        redir_hit;
  logic        eff_v;
  logic [31:0] eff_tgt;
  logic [31:0] eff_after;
  logic [31:0] npc_tgt;
  logic [31:0] pc_inc;
  logic [31:0] fd_after;

  fetch_ctrl_npc npc (
    .npc_mod (d_npc_mod),
    .i_pc    (pc_q),
    .d_pc    (fd_q.pc),
    .imm26   (fd_q.instr[25:0]),
    .reg32   (d_reg32),
    .target  (npc_tgt)
  );

  assign accept    = d_accept & fd_valid_q;
  // The delay slot is never a control transfer, so a pending redirect blocks capture.
  assign cap       = accept & (d_npc_mod != NPC_ADD4) & ~redir_v_q;
  assign done      = (state_q == ST_FETCH) & imem_ready;
  assign pc_inc    = pc_q + 32'd4;
  assign fd_after  = fd_q.pc + 32'd8;

  // A redirect captured this cycle is visible to a completion in the same cycle.
  assign eff_v     = redir_v_q | cap;
  assign eff_tgt   = redir_v_q ? redir_tgt_q : npc_tgt;
  assign eff_after = redir_v_q ? redir_after_q : fd_after;
  assign drop      = done & eff_v & (pc_q == eff_after);
  assign redir_hit = eff_v & (pc_inc == eff_after);

  assign imem_req  = (state_q == ST_FETCH);
  assign imem_addr = pc_q;
  assign fd_valid  = fd_valid_q;
  assign fd_pc     = fd_q.pc;
  assign fd_instr  = fd_q.instr;
  assign state     = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      fd_valid_q    <= 1'b0;
      fd_q          <= '0;
      skid_q        <= '0;
      redir_v_q     <= 1'b0;
      redir_tgt_q   <= '0;
      redir_after_q <= '0;
    end else begin
      case (state_q)
        ST_BOOT: begin
          state_q <= ST_FETCH;
        end

        ST_FETCH: begin
          if (drop) begin
            // Word beyond the delay slot: discard it and jump.
            pc_q      <= eff_tgt;
            redir_v_q <= 1'b0;
            if (accept) fd_valid_q <= 1'b0;
          end else if (done) begin
            if (!fd_valid_q || accept) begin
              fd_valid_q <= 1'b1;
              fd_q       <= '{pc: pc_q, instr: imem_rdata};
            end else begin
              skid_q  <= '{pc: pc_q, instr: imem_rdata};
              state_q <= ST_FULL;
            end
            if (redir_hit) begin
              pc_q      <= eff_tgt;
              redir_v_q <= 1'b0;
            end else begin
              pc_q <= pc_inc;
              if (cap) begin
                redir_v_q     <= 1'b1;
                redir_tgt_q   <= npc_tgt;
                redir_after_q <= fd_after;
              end
            end
          end else begin
            if (accept) fd_valid_q <= 1'b0;
            if (cap) begin
              redir_v_q     <= 1'b1;
              redir_tgt_q   <= npc_tgt;
              redir_after_q <= fd_after;
            end
          end
        end

        ST_FULL: begin
          if (accept) begin
            fd_q    <= skid_q;
            state_q <= ST_FETCH;
          end
          if (cap) begin
            // Delay slot already sits in the skid: jump without fetching pc_q.
            if (pc_q == fd_after) begin
              pc_q <= npc_tgt;
            end else begin
              redir_v_q     <= 1'b1;
              redir_tgt_q   <= npc_tgt;
              redir_after_q <= fd_after;
            end
          end
        end

        default: begin
          state_q <= ST_BOOT;
        end
      endcase
    end
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port imem_req  output  1  instruction fetch request.
REQ-005 SHALL have port imem_addr  output  32  fetch address.
REQ-006 SHALL have port imem_ready  input  1  fetch completes this cycle.
REQ-007 SHALL have port imem_rdata  input  32  fetched word, valid when imem_ready=1.
REQ-008 SHALL have port fd_valid  output  1  the F/D register holds an instruction.
REQ-009 SHALL have port fd_pc  output  32  PC of the F/D instruction.
REQ-010 SHALL have port fd_instr  output  32  the F/D instruction word.
REQ-011 SHALL have port d_accept  input  1  D consumes F/D this cycle (hazard unit's not-stall); ignored when fd_valid=0.
REQ-012 SHALL have port d_npc_mod  input  3  resolved next-PC mode of the F/D instruction: add4=0, brch=1 (taken only), j=2, jr=3.
REQ-013 SHALL have port d_reg32  input  32  forwarded rs value for jr.

Function
REQ-014 SHALL implement states BOOT, FETCH and FULL; BOOT is left after one cycle to FETCH.
REQ-015 SHALL drive imem_req=1 only in FETCH, with imem_addr=pc_q held stable until imem_ready.
REQ-016 On completion with F/D empty, or with F/D consumed in the same cycle, SHALL load F/D with {pc_q, imem_rdata} at the next edge.
REQ-017 On completion while F/D is full and not consumed, SHALL write the word into a 1-entry skid buffer and go to FULL.
REQ-018 In FULL, SHALL move the skid entry into F/D at the edge where d_accept=1, then return to FETCH.
REQ-019 On d_accept with fd_valid=1 and no new word, SHALL clear fd_valid.
REQ-020 On d_accept with fd_valid=1 and d_npc_mod!=add4, SHALL compute the target via npc using: I_pc=pc_q, D_pc=fd_pc, imm26=fd_instr[25:0], reg32=d_reg32.
REQ-021 On the same condition, SHALL capture redir_v=1, redir_tgt, and redir_after=fd_pc+8 (first address beyond the delay slot).
REQ-022 SHALL apply the capture-cycle redirect combinationally (bypass) to any completion in the same cycle.
REQ-023 On every fetch completion, SHALL set next pc_q to redir_tgt if a redirect is active and pc_q+4==redir_after, otherwise pc_q+4; a redirect consumed this way clears redir_v.
REQ-024 SHALL drop a completion whose address equals an active redir_after (no F/D/skid write), set pc_q<=redir_tgt, and clear redir_v.
REQ-025 On capture while in FULL with pc_q==redir_after, SHALL set pc_q<=redir_tgt immediately without fetching.
REQ-026 SHALL always let the delay slot (fd_pc+4) complete and enter F/D.
REQ-027 A second redirect while redir_v=1 is not possible (the delay slot is never a branch) and SHALL be ignored.
REQ-028 SHALL perform all address arithmetic mod 2^32, with the brch offset sign-extended imm16<<2.

Reset
REQ-029 With reset=1 at an edge, SHALL set: state=BOOT, pc_q=RESET_PC, fd_valid=0, fd_pc=0, fd_instr=0, skid empty, redir_v=0; imem_req=0 during the following cycle.
REQ-030 Reset mid-fetch SHALL abandon the outstanding request; an imem_ready in the BOOT cycle SHALL be ignored.

Structure
REQ-031 SHALL take the npc_mod encodings, state encodings and RESET_PC default from the shared define file.
REQ-032 SHALL instantiate exactly one sub-module, npc, for target computation.

Verification
REQ-033 Reset, then imem_ready=1 every cycle, d_accept=1 -> fd_pc sequence 0x3000, 0x3004, 0x3008 on consecutive cycles from cycle 2.
REQ-034 Branch at 0x3000 taken, imm16=0x0004 -> fd_pc 0x3000, 0x3004 (delay slot), 0x3014; no fd_pc 0x3008.
REQ-035 jr at 0x3010, d_reg32=0x0000_4000, imem_ready low 3 cycles on the delay slot -> delay slot 0x3014 delivered, then 0x4000; imem_addr stable while waiting.
REQ-036 d_accept=0 for 4 cycles with F/D full -> state FULL, imem_req=0, no loss; on release, the skid word appears in fd next cycle.
REQ-037 j (imm26=0x0000_100) accepted while FULL holding the delay slot and pc_q==fd_pc+8 -> next imem_addr=0x0000_0400, no fetch of the dropped address.
REQ-038 reset asserted while imem_req=1 -> next cycle fd_valid=0, imem_req=0; the cycle after, imem_addr=0x3000.
